// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline latch with load alignment/extension, write-back register file
// (write-first bypass on both read ports) and a retired-instruction counter.
module mem_wb_writeback #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_N  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [2:0]        LoadSize,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] Result,
  input  logic [4:0]        WriteReg,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              align_err,
  output logic [31:0]       retired
);

  localparam logic [2:0] LdW  = 3'b000;
  localparam logic [2:0] LdH  = 3'b001;
  localparam logic [2:0] LdHu = 3'b010;
  localparam logic [2:0] LdB  = 3'b011;
  localparam logic [2:0] LdBu = 3'b100;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [2:0]        load_size;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] result;
    logic [4:0]        write_reg;
  } latch_t;

  latch_t            latch_q, latch_d;
  logic              committed_q, committed_d;
  logic [31:0]       retired_q, retired_d;
  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];

  logic [1:0]        off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;
  logic              is_half, is_byte, is_word;
  logic              commit, reg_we;

  // Latch next state: flush beats stall; a held entry remembers it already committed.
  always_comb begin
    latch_d     = latch_q;
    committed_d = committed_q;
    if (flush) begin
      latch_d     = '0;
      committed_d = 1'b0;
    end else if (stall) begin
      committed_d = committed_q | latch_q.valid;
    end else begin
      latch_d.valid      = 1'b1;
      latch_d.reg_write  = RegWrite;
      latch_d.mem_to_reg = MemtoReg;
      latch_d.load_size  = LoadSize;
      latch_d.read_data  = ReadData;
      latch_d.result     = Result;
      latch_d.write_reg  = WriteReg;
      committed_d        = 1'b0;
    end
  end

  // Little-endian lane select; halfwords are picked by address bit 1.
  always_comb begin
    off     = latch_q.result[1:0];
    ld_byte = latch_q.read_data[{off, 3'b000} +: 8];
    ld_half = latch_q.read_data[{off[1], 4'b0000} +: 16];
    is_half = (latch_q.load_size == LdH) || (latch_q.load_size == LdHu);
    is_byte = (latch_q.load_size == LdB) || (latch_q.load_size == LdBu);
    is_word = ~is_half & ~is_byte;
    case (latch_q.load_size)
      LdH:     ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
      LdHu:    ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
      LdB:     ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LdBu:    ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
      default: ld_ext = latch_q.read_data;
    endcase
  end

  always_comb begin
    align_err = latch_q.valid & latch_q.mem_to_reg &
                ((is_word & (off != 2'b00)) | (is_half & off[0]));
    wb_data   = latch_q.mem_to_reg ? ld_ext : latch_q.result;
    wb_reg    = latch_q.write_reg;
    wb_valid  = latch_q.valid & latch_q.reg_write & (latch_q.write_reg != 5'd0) & ~align_err;
    commit    = latch_q.valid & ~committed_q;
    reg_we    = wb_valid & ~committed_q;
    retired   = retired_q;
  end

  always_comb begin
    retired_d = retired_q + {31'b0, commit};
    regs_d    = regs_q;
    if (reg_we) regs_d[wb_reg] = wb_data;
    regs_d[0] = '0;
  end

  // Combinational reads with write-first bypass from the write-back stage.
  always_comb begin
    if (rs_addr == 5'd0)                     rs_data = '0;
    else if (wb_valid && rs_addr == wb_reg)  rs_data = wb_data;
    else                                     rs_data = regs_q[rs_addr];
    if (rt_addr == 5'd0)                     rt_data = '0;
    else if (wb_valid && rt_addr == wb_reg)  rt_data = wb_data;
    else                                     rt_data = regs_q[rt_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q     <= '0;
      committed_q <= 1'b0;
      retired_q   <= '0;
      regs_q      <= '{default: '0};
    end else begin
      latch_q     <= latch_d;
      committed_q <= committed_d;
      retired_q   <= retired_d;
      regs_q      <= regs_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: directed scenarios plus randomized
// traffic compared against a behavioural pipeline/register-file model.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        reset, stall, flush, RegWrite, MemtoReg;
  logic [2:0]  LoadSize;
  logic [31:0] ReadData, Result;
  logic [4:0]  WriteReg, rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_data, retired;
  logic        wb_valid, align_err;
  logic [4:0]  wb_reg;

  int errors;
  int checks;

  // Reference model: one in-flight instruction plus architectural state.
  logic        l_valid, l_rw, l_m2r, l_done;
  logic [2:0]  l_ls;
  logic [31:0] l_rd, l_res;
  logic [4:0]  l_wr;
  logic [31:0] mreg [32];
  logic [31:0] mret;

  mem_wb_writeback #(.DATA_W(32), .REG_N(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .LoadSize(LoadSize),
    .ReadData(ReadData), .Result(Result), .WriteReg(WriteReg),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .align_err(align_err), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_load();
    logic [31:0] b, h;
    b = (l_rd >> (8 * l_res[1:0])) % 256;
    h = (l_rd >> (16 * l_res[1])) % 65536;
    case (l_ls)
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd2:    return h;
      3'd3:    return (b >= 128) ? b - 256 : b;
      3'd4:    return b;
      default: return l_rd;
    endcase
  endfunction

  function automatic logic m_align();
    if (!(l_valid && l_m2r)) return 1'b0;
    if (l_ls == 3'd1 || l_ls == 3'd2) return l_res[0];
    if (l_ls == 3'd3 || l_ls == 3'd4) return 1'b0;
    return l_res[1:0] != 2'd0;
  endfunction

  function automatic logic [31:0] m_data();
    return l_m2r ? m_load() : l_res;
  endfunction

  function automatic logic m_wbv();
    return l_valid && l_rw && (l_wr != 5'd0) && !m_align();
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_wbv() && a == l_wr) return m_data();
    return mreg[a];
  endfunction

  task automatic model_edge();
    logic        wbv;
    logic [31:0] d;
    if (reset) begin
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      mret = 0; l_valid = 0; l_rw = 0; l_m2r = 0; l_done = 0;
      l_ls = 0; l_rd = 0; l_res = 0; l_wr = 0;
    end else begin
      wbv = m_wbv();
      d   = m_data();
      if (l_valid && !l_done) begin
        mret = mret + 1;
        if (wbv) mreg[l_wr] = d;
      end
      if (flush) begin
        l_valid = 0; l_rw = 0; l_m2r = 0; l_done = 0;
        l_ls = 0; l_rd = 0; l_res = 0; l_wr = 0;
      end else if (stall) begin
        l_done = l_done | l_valid;
      end else begin
        l_valid = 1; l_rw = RegWrite; l_m2r = MemtoReg; l_ls = LoadSize;
        l_rd = ReadData; l_res = Result; l_wr = WriteReg; l_done = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic rw, input logic m2r, input logic [2:0] ls,
                         input logic [31:0] rd, input logic [31:0] res, input logic [4:0] wr);
    reset = 0; stall = 0; flush = 0;
    RegWrite = rw; MemtoReg = m2r; LoadSize = ls;
    ReadData = rd; Result = res; WriteReg = wr;
  endtask

  task automatic set_idle();
    set_ins(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    flush = 1;
  endtask

  task automatic test_reset();
    set_ins(1'b1, 1'b0, 3'd0, 32'd0, 32'h0000_00AA, 5'd3);
    reset = 1; rs_addr = 5'd3; rt_addr = 5'd0;
    tick();
    tick();
    set_idle();
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %h want 0", wb_valid); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align got %h want 0", align_err); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %h want 0", retired); end
    checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL reset_rs got %h want 0", rs_data); end
    checks++; if (rt_data !== 32'd0) begin errors++; $display("FAIL reset_rt got %h want 0", rt_data); end
  endtask

  task automatic test_alu_write();
    set_ins(1'b1, 1'b0, 3'd0, 32'd0, 32'h0000_1234, 5'd5);
    rs_addr = 5'd5; rt_addr = 5'd5;
    tick();
    set_idle();
    #1;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid got %h want 1", wb_valid); end
    checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL alu_wb_data got %h want 1234", wb_data); end
    checks++; if (rs_data !== 32'h1234) begin errors++; $display("FAIL alu_bypass_rs got %h want 1234", rs_data); end
    checks++; if (rt_data !== 32'h1234) begin errors++; $display("FAIL alu_bypass_rt got %h want 1234", rt_data); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_bubble got %h want 0", wb_valid); end
    checks++; if (rs_data !== 32'h1234) begin errors++; $display("FAIL alu_array got %h want 1234", rs_data); end
  endtask

  task automatic test_loads();
    logic [2:0]  ls  [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
    logic [31:0] res [5] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100};
    logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_80FF,
                             32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      set_ins(1'b1, 1'b1, ls[i], 32'h80FF_7F01, res[i], 5'd3);
      tick();
      set_idle();
      #1;
      checks++; if (wb_data !== exp[i]) begin errors++; $display("FAIL load_%0d got %h want %h", i, wb_data, exp[i]); end
      checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL load_align_%0d got %h want 0", i, align_err); end
      tick();
    end
  endtask

  task automatic test_misalign();
    logic [31:0] base;
    base = mret;
    set_ins(1'b1, 1'b0, 3'd0, 32'd0, 32'h55, 5'd9);
    tick();
    set_ins(1'b1, 1'b1, 3'd0, 32'h1234_5678, 32'h102, 5'd9);
    rs_addr = 5'd9;
    tick();
    set_ins(1'b1, 1'b1, 3'd1, 32'h1234_5678, 32'h101, 5'd9);
    #1;
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL mis_lw_align got %h want 1", align_err); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mis_lw_wbv got %h want 0", wb_valid); end
    checks++; if (rs_data !== 32'h55) begin errors++; $display("FAIL mis_lw_read got %h want 55", rs_data); end
    tick();
    set_idle();
    #1;
    checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL mis_lh_align got %h want 1", align_err); end
    tick();
    checks++; if (retired !== base + 3) begin errors++; $display("FAIL mis_retired got %h want %h", retired, base + 3); end
    checks++; if (rs_data !== 32'h55) begin errors++; $display("FAIL mis_noreg got %h want 55", rs_data); end
  endtask

  task automatic test_stall();
    logic [31:0] base;
    set_ins(1'b1, 1'b0, 3'd0, 32'd0, 32'hCAFE_0007, 5'd7);
    rs_addr = 5'd7; rt_addr = 5'd12;
    tick();
    base = mret;
    for (int k = 0; k < 3; k++) begin
      set_ins(1'b1, 1'b0, 3'd0, 32'd0, $urandom, 5'd12);
      stall = 1;
      #1;
      checks++; if (wb_valid !== 1'b1 || wb_reg !== 5'd7) begin errors++; $display("FAIL stall_hold_%0d got %h/%h want 1/07", k, wb_valid, wb_reg); end
      checks++; if (rs_data !== 32'hCAFE_0007) begin errors++; $display("FAIL stall_rs_%0d got %h want cafe0007", k, rs_data); end
      tick();
    end
    set_idle();
    #1;
    checks++; if (retired !== base + 1) begin errors++; $display("FAIL stall_retired got %h want %h", retired, base + 1); end
    tick();
    checks++; if (retired !== base + 1) begin errors++; $display("FAIL stall_retired2 got %h want %h", retired, base + 1); end
    checks++; if (rs_data !== 32'hCAFE_0007) begin errors++; $display("FAIL stall_array got %h want cafe0007", rs_data); end
    checks++; if (rt_data !== m_read(5'd12)) begin errors++; $display("FAIL stall_r12 got %h want %h", rt_data, m_read(5'd12)); end
    set_ins(1'b1, 1'b0, 3'd0, 32'd0, 32'h1111, 5'd13);
    flush = 1; stall = 1; rs_addr = 5'd13;
    tick();
    set_idle();
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fs_wbv got %h want 0", wb_valid); end
    tick();
    checks++; if (retired !== base + 1) begin errors++; $display("FAIL fs_retired got %h want %h", retired, base + 1); end
    checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL fs_r13 got %h want 0", rs_data); end
  endtask

  task automatic test_r0();
    set_ins(1'b1, 1'b0, 3'd0, 32'd0, 32'hDEAD_BEEF, 5'd0);
    rs_addr = 5'd0; rt_addr = 5'd0;
    tick();
    set_idle();
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL r0_wbv got %h want 0", wb_valid); end
    checks++; if (rs_data !== 32'd0) begin errors++; $display("FAIL r0_bypass got %h want 0", rs_data); end
    tick();
    checks++; if (rt_data !== 32'd0) begin errors++; $display("FAIL r0_array got %h want 0", rt_data); end
  endtask

  task automatic test_back_to_back_reset();
    logic [31:0] base;
    base = mret;
    for (int i = 1; i <= 10; i++) begin
      set_ins(1'b1, 1'b0, 3'd0, 32'd0, 32'h100 + i, 5'(i));
      tick();
      checks++; if (wb_valid !== 1'b1 || wb_reg !== 5'(i) || wb_data !== 32'h100 + i) begin
        errors++; $display("FAIL b2b_%0d got %h/%h/%h want 1/%h/%h", i, wb_valid, wb_reg, wb_data, 5'(i), 32'h100 + i);
      end
    end
    set_ins(1'b1, 1'b0, 3'd0, 32'd0, 32'h77, 5'd11);
    tick();
    checks++; if (retired !== base + 10) begin errors++; $display("FAIL b2b_retired got %h want %h", retired, base + 10); end
    rs_addr = 5'd4;
    #1;
    checks++; if (rs_data !== 32'h104) begin errors++; $display("FAIL b2b_r4 got %h want 104", rs_data); end
    reset = 1;
    tick();
    set_idle();
    #1;
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL rst_retired got %h want 0", retired); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wbv got %h want 0", wb_valid); end
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a); rt_addr = 5'(31 - a);
      #1;
      checks++; if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
        errors++; $display("FAIL rst_reg_%0d got %h/%h want 0/0", a, rs_data, rt_data);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_ins(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom, $urandom, 5'($urandom_range(0, 7)));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 49) == 0);
      rs_addr = 5'($urandom_range(0, 7));
      rt_addr = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 7));
      #1;
      checks++; if (wb_valid !== m_wbv()) begin errors++; $display("FAIL rnd_wbv_%0d got %h want %h", n, wb_valid, m_wbv()); end
      checks++; if (align_err !== m_align()) begin errors++; $display("FAIL rnd_align_%0d got %h want %h", n, align_err, m_align()); end
      checks++; if (retired !== mret) begin errors++; $display("FAIL rnd_retired_%0d got %h want %h", n, retired, mret); end
      checks++; if (rs_data !== m_read(rs_addr)) begin errors++; $display("FAIL rnd_rs_%0d got %h want %h", n, rs_data, m_read(rs_addr)); end
      checks++; if (rt_data !== m_read(rt_addr)) begin errors++; $display("FAIL rnd_rt_%0d got %h want %h", n, rt_data, m_read(rt_addr)); end
      if (l_valid && !m_align()) begin
        checks++; if (wb_data !== m_data() || wb_reg !== l_wr) begin
          errors++; $display("FAIL rnd_wbdata_%0d got %h/%h want %h/%h", n, wb_data, wb_reg, m_data(), l_wr);
        end
      end
      tick();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mret = 0; l_valid = 0; l_rw = 0; l_m2r = 0; l_done = 0;
    l_ls = 0; l_rd = 0; l_res = 0; l_wr = 0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    test_reset();
    test_alu_write();
    test_loads();
    test_misalign();
    test_stall();
    test_r0();
    test_back_to_back_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
